// File: rtl/avalon_switch_controller_if.sv
// ----------------------------------------------------------------------------
// avalon_switch_controller_if
//   Bundles the request, downstream-status and status-output signals of the
//   4-way switch controller.
//   slave  : controller side (consumes requests/status, drives select/flags)
//   master : requester/environment side
//   Signals:
//     req_valid, req_select   channel-change request strobe and target channel
//     source_valid/_error     valid and error seen downstream of the switcher
//     fault_clear             strobe clearing the sticky fault flag
//     select                  registered channel select to the switcher
//     gated_valid             source_valid masked while settling
//     busy, fault, fault_chan settle indicator, sticky fault, faulted channel
// ----------------------------------------------------------------------------
interface avalon_switch_controller_if;
    logic       req_valid;
    logic [1:0] req_select;
    logic       source_valid;
    logic [1:0] source_error;
    logic       fault_clear;
    logic [1:0] select;
    logic       gated_valid;
    logic       busy;
    logic       fault;
    logic [1:0] fault_chan;

    modport slave (
        input  req_valid, req_select, source_valid, source_error, fault_clear,
        output select, gated_valid, busy, fault, fault_chan
    );

    modport master (
        output req_valid, req_select, source_valid, source_error, fault_clear,
        input  select, gated_valid, busy, fault, fault_chan
    );
endinterface

// File: rtl/avalon_switch_controller.sv
// ----------------------------------------------------------------------------
// avalon_switch_controller
//   Drives the channel select of a 4-way stream switcher. A channel change
//   masks downstream valid for SETTLE_CYCLES cycles; requests arriving while
//   settling are held in a one-deep "last wins" pending slot. Runs of
//   ERR_LIMIT consecutive errored samples raise a sticky fault and fall back
//   to channel 0.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    avalon_switch_controller_if.slave (requests, status, outputs)
// ----------------------------------------------------------------------------
module avalon_switch_controller #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_LIMIT     = 8
) (
    input logic                        clk,
    input logic                        reset,
    avalon_switch_controller_if.slave  bus
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [7:0] ERR_MAX     = 8'(ERR_LIMIT);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t     state;
    logic [7:0] settle_cnt;
    logic [7:0] err_cnt;
    logic       pend_vld;
    logic [1:0] pend_chan;
    logic [1:0] select_r;
    logic [1:0] fault_chan_r;
    logic       busy_r;
    logic       fault_r;

    logic       fault_hit;
    logic       eff_vld;
    logic [1:0] eff_sel;

    // Saturating run-length of errored valid samples; idle cycles hold it.
    function automatic logic [7:0] err_update(input logic [7:0] cnt,
                                              input logic       vld,
                                              input logic [1:0] err);
        logic [7:0] r;
        r = cnt;
        if (vld) begin
            if (err != 2'b00)
                r = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            else
                r = 8'd0;
        end
        return r;
    endfunction

    assign fault_hit = (state == IDLE) && (err_cnt >= ERR_MAX);
    // A live request outranks whatever was left pending from the last settle.
    assign eff_vld   = bus.req_valid | pend_vld;
    assign eff_sel   = bus.req_valid ? bus.req_select : pend_chan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            settle_cnt   <= 8'd0;
            err_cnt      <= 8'd0;
            pend_vld     <= 1'b0;
            pend_chan    <= 2'd0;
            select_r     <= 2'd0;
            fault_chan_r <= 2'd0;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            // Set wins over a coincident clear.
            if (fault_hit)
                fault_r <= 1'b1;
            else if (bus.fault_clear)
                fault_r <= 1'b0;

            case (state)
                IDLE: begin
                    // Pending is consumed (or discarded) on every IDLE cycle.
                    pend_vld <= 1'b0;
                    if (fault_hit) begin
                        fault_chan_r <= select_r;
                        err_cnt      <= 8'd0;
                        if (select_r != 2'd0) begin
                            select_r   <= 2'd0;
                            state      <= SETTLE;
                            busy_r     <= 1'b1;
                            settle_cnt <= SETTLE_INIT;
                        end
                    end else if (!fault_r && eff_vld && (eff_sel != select_r)) begin
                        select_r   <= eff_sel;
                        state      <= SETTLE;
                        busy_r     <= 1'b1;
                        settle_cnt <= SETTLE_INIT;
                        err_cnt    <= 8'd0;
                    end else begin
                        err_cnt <= err_update(err_cnt, bus.source_valid, bus.source_error);
                    end
                end
                SETTLE: begin
                    if (fault_r) begin
                        pend_vld <= 1'b0;
                    end else if (bus.req_valid) begin
                        pend_vld  <= 1'b1;
                        pend_chan <= bus.req_select;
                    end
                    // Counter holds the number of masked cycles still to come,
                    // including the current one.
                    if (settle_cnt <= 8'd1) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.select      = select_r;
    assign bus.busy        = busy_r;
    assign bus.fault       = fault_r;
    assign bus.fault_chan  = fault_chan_r;
    assign bus.gated_valid = bus.source_valid & ~busy_r;

endmodule

// File: doc/avalon_switch_controller.md
AVALON_SWITCH_CONTROLLER -- requirements
Module: avalon_switch_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, number of cycles valid is masked after a select change (legal range 1..255).
REQ-002 Parameter ERR_LIMIT, default 8, consecutive errored valid samples that trigger fallback (legal range 1..255).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  one-cycle channel-change request strobe.
REQ-006 Port req_select  input  2  requested channel, sampled when req_valid=1.
REQ-007 Port source_valid  input  1  valid from downstream of the 4-way switcher.
REQ-008 Port source_error  input  2  error from downstream of the 4-way switcher.
REQ-009 Port fault_clear  input  1  one-cycle strobe clearing fault.
REQ-010 Port select  output  2  registered channel select driven to the switcher.
REQ-011 Port gated_valid  output  1  source_valid AND NOT settling (combinational).
REQ-012 Port busy  output  1  registered; 1 while in SETTLE.
REQ-013 Port fault  output  1  registered sticky fallback flag.
REQ-014 Port fault_chan  output  2  registered channel that was active when fault set.

Function
REQ-015 States SHALL be IDLE and SETTLE; an 8-bit settle counter, 8-bit error counter and 3-bit pending slot (valid + 2-bit channel) SHALL exist.
REQ-016 In IDLE, req_valid=1 with req_select != select SHALL load select<=req_select at the next edge, enter SETTLE, load settle counter with SETTLE_CYCLES.
REQ-017 Request at edge N SHALL give new select, busy=1 and masking from cycle N+1 through N+SETTLE_CYCLES inclusive; IDLE again at N+SETTLE_CYCLES+1.
REQ-018 In IDLE, req_valid=1 with req_select == select SHALL be ignored (no SETTLE, no busy).
REQ-019 In SETTLE, settle counter SHALL decrement each cycle; on reaching 1, state SHALL return to IDLE next edge.
REQ-020 req_valid in SETTLE SHALL write the pending slot (last request wins, overwriting older pending).
REQ-021 On the IDLE cycle after SETTLE, a valid pending entry SHALL be processed exactly as a fresh request (REQ-016/018) and cleared; a simultaneous live req_valid that cycle SHALL take priority and discard pending.
REQ-022 gated_valid SHALL equal source_valid when IDLE and 0 when SETTLE; source_data/source_error routing is unaffected.
REQ-023 Error counter SHALL update only in IDLE: +1 on source_valid=1 with source_error!=0 (saturate at 255), clear on source_valid=1 with source_error=0, hold on source_valid=0; cleared on entering SETTLE.
REQ-024 Counter reaching ERR_LIMIT SHALL set fault=1 and fault_chan<=select at the next edge and clear the counter.
REQ-025 On that event with select!=0, controller SHALL force select<=0 and enter SETTLE (same timing as REQ-017); with select==0, select unchanged and no SETTLE.
REQ-026 While fault=1, req_valid SHALL be ignored and the pending slot cleared; fallback event coincident with req_valid SHALL discard the request.
REQ-027 fault_clear SHALL clear fault at the next edge; fault-set coincident with fault_clear SHALL leave fault=1 (set wins); fault_chan holds its value until next fault.
REQ-028 No combinational path from req_* to select; select changes only on clock edges.

Reset
REQ-029 reset=1 SHALL immediately force: state IDLE, select=0, busy=0, fault=0, fault_chan=0, counters 0, pending invalid; gated_valid then follows source_valid.
REQ-030 Reset asserted mid-SETTLE SHALL abort the settle, with operation resuming from IDLE on channel 0 after release.

Verification
REQ-031 After reset, req_valid=1, req_select=2 at edge N, source_valid=1 constant -> select=2 at N+1; gated_valid=0 and busy=1 for cycles N+1..N+4; gated_valid=1 from N+5.
REQ-032 In SETTLE, requests for 1 then 3 -> after settle, select=3 with second settle of 4 cycles; channel 1 never selected.
REQ-033 select=1, 8 consecutive valid samples with source_error=2'b01 -> fault=1, fault_chan=1, select=0, 4-cycle mask; req_valid ignored until fault_clear pulse.
REQ-034 select=0, errored samples interleaved with source_valid=0 cycles, one clean sample after 7 errors -> no fault; 8 further errors -> fault=1, select stays 0, busy stays 0.
REQ-035 reset pulsed 2 cycles into SETTLE after switch to 3 -> select=0, busy=0 immediately; req_select=3 after release -> normal 4-cycle settle.
